// File: rtl/reg_file_mp.sv
// Parametrised 2R2W register file with fixed write priority (port 1 wins),
// write-to-read bypass and a hardware clear sequencer that zeroes every entry.
module reg_file_mp #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              we0,
  input  logic [AWIDTH-1:0] wa0,
  input  logic [DWIDTH-1:0] wd0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] wa1,
  input  logic [DWIDTH-1:0] wd1,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2
);
  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH-1);

  state_t                         state;
  logic [AWIDTH-1:0]              clr_idx;
  logic [DEPTH-1:0][DWIDTH-1:0]   mem;
  logic                           ready, ok0, ok1;
  logic [1:0][AWIDTH-1:0]         ra;
  logic [1:0][DWIDTH-1:0]         rd;

  assign busy = (state == CLEAR);

  // A write is "ok" only if it will really commit; bypass keys off the same term
  assign ready = (state == READY) && !rst;
  assign ok0   = ready && we0 && ({1'b0, wa0} < DEPTH_W) && !((ZERO_REG != 0) && (wa0 == '0));
  assign ok1   = ready && we1 && ({1'b0, wa1} < DEPTH_W) && !((ZERO_REG != 0) && (wa1 == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == LAST) begin
            state   <= READY;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        READY: begin
          if (clr) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; the clear sequence owns zeroing.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (!rst && (state == CLEAR) && (clr_idx == AWIDTH'(e)))
        mem[e] <= '0;
      else if (ok1 && (wa1 == AWIDTH'(e)))
        mem[e] <= wd1;
      else if (ok0 && (wa0 == AWIDTH'(e)))
        mem[e] <= wd0;
    end
  end

  assign ra  = {ra2, ra1};
  assign rd1 = rd[0];
  assign rd2 = rd[1];

  always_comb begin
    rd = '0;
    for (int p = 0; p < 2; p++) begin
      if (busy || ({1'b0, ra[p]} >= DEPTH_W) || ((ZERO_REG != 0) && (ra[p] == '0)))
        rd[p] = '0;
      else if (ok1 && (wa1 == ra[p]))
        rd[p] = wd1;
      else if (ok0 && (wa0 == ra[p]))
        rd[p] = wd0;
      else
        for (int e = 0; e < DEPTH; e++)
          if (ra[p] == AWIDTH'(e)) rd[p] = mem[e];
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: three instances (default, ZERO_REG=0, DEPTH=24)
// share stimulus; expectations are queued and checked by a negedge monitor.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;

  localparam int A_RD1 = 0, A_RD2 = 1, A_BUSY = 2;
  localparam int Z_RD1 = 3, Z_RD2 = 4, Z_BUSY = 5;
  localparam int D_RD1 = 6, D_RD2 = 7, D_BUSY = 8;

  logic          clk = 1'b0;
  logic          rst, clr, we0, we1;
  logic [AW-1:0] wa0, wa1, ra1, ra2;
  logic [DW-1:0] wd0, wd1;
  logic          busy_a, busy_z, busy_d;
  logic [DW-1:0] rd1_a, rd2_a, rd1_z, rd2_z, rd1_d, rd2_d;

  always #5 clk = ~clk;

  reg_file_mp #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a));

  reg_file_mp #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(32), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_z),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z));

  reg_file_mp #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(24), .ZERO_REG(1)) dut_d (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_d),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_d), .rd2(rd2_d));

  typedef struct {
    int            sig;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [DW-1:0] probe(input int sig);
    case (sig)
      A_RD1:   return rd1_a;
      A_RD2:   return rd2_a;
      A_BUSY:  return {{(DW-1){1'b0}}, busy_a};
      Z_RD1:   return rd1_z;
      Z_RD2:   return rd2_z;
      Z_BUSY:  return {{(DW-1){1'b0}}, busy_z};
      D_RD1:   return rd1_d;
      D_RD2:   return rd2_d;
      default: return {{(DW-1){1'b0}}, busy_d};
    endcase
  endfunction

  task automatic chk(input int sig, input logic [DW-1:0] e, input string nm);
    exp_t x;
    x.sig = sig; x.exp = e; x.name = nm;
    q.push_back(x);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t m;
    while (q.size() > 0) begin
      m = q.pop_front();
      n_chk++;
      if (probe(m.sig) === m.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", m.name, probe(m.sig), m.exp);
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra1 = 5'd5; ra2 = 5'd31;

    // reset held 3 edges
    step; step; step;
    chk(A_BUSY, 1, "rst_busy"); chk(A_RD1, 0, "rst_rd1"); chk(A_RD2, 0, "rst_rd2");
    chk(D_BUSY, 1, "rst_busy_d24");

    // release: exactly 32 busy cycles, write during busy dropped
    rst = 1'b0; we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hFFFF_FFFF;
    for (int k = 0; k < 32; k++) begin
      if (k == 20) we0 = 1'b0;
      chk(A_BUSY, 1, "init_busy"); chk(A_RD1, 0, "init_rd1"); chk(A_RD2, 0, "init_rd2");
      if (k == 23) chk(D_BUSY, 1, "init_busy_d24_last");
      if (k == 24) chk(D_BUSY, 0, "init_busy_d24_done");
      step;
    end
    ra1 = 5'd7;
    chk(A_BUSY, 0, "init_done"); chk(A_RD1, 0, "busy_write_dropped");
    step;

    // write / read, x0
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD_BEEF; ra1 = 5'd3;
    chk(A_RD1, 32'hDEAD_BEEF, "bypass_w0_addr3");
    step; we0 = 1'b0;
    chk(A_RD1, 32'hDEAD_BEEF, "mem_read3");
    step;
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra1 = 5'd0;
    step; we0 = 1'b0;
    chk(A_RD1, 0, "x0_read"); chk(Z_RD1, 32'h1234, "noz_read0");
    step;

    // dual write priority and two addresses
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hAAAA; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h5555;
    step; we0 = 1'b0; we1 = 1'b0; ra1 = 5'd4;
    chk(A_RD1, 32'h5555, "prio_port1");
    step;
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h88; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
    step; we0 = 1'b0; we1 = 1'b0; ra1 = 5'd8; ra2 = 5'd9;
    chk(A_RD1, 32'h88, "dual_w8"); chk(A_RD2, 32'h99, "dual_w9");
    step;

    // bypass
    ra1 = 5'd10; we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h77;
    chk(A_RD1, 32'h77, "bypass_p0");
    step;
    we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h99;
    chk(A_RD1, 32'h99, "bypass_p1_wins");
    step;
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h55; ra2 = 5'd0;
    chk(A_RD2, 0, "bypass_x0_blocked"); chk(Z_RD2, 32'h55, "bypass_noz_addr0");
    step; we0 = 1'b0; we1 = 1'b0;

    // fill 1..31 with index
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = DW'(i);
      step;
    end
    we0 = 1'b0; ra1 = 5'd17; ra2 = 5'd31;
    chk(A_RD1, 17, "fill17"); chk(A_RD2, 31, "fill31"); chk(D_RD1, 17, "fill17_d24");
    chk(D_RD2, 0, "oor_read31_d24");
    step;

    // runtime clear, second clr pulse mid-sequence ignored
    clr = 1'b1;
    chk(A_BUSY, 0, "clr_cycle_ready");
    step; clr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 5) clr = 1'b1;
      if (k == 6) clr = 1'b0;
      ra1 = 5'(k); ra2 = 5'(31 - k);
      chk(A_BUSY, 1, "rclr_busy"); chk(A_RD1, 0, "rclr_rd1"); chk(A_RD2, 0, "rclr_rd2");
      step;
    end
    chk(A_BUSY, 0, "rclr_done");
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      chk(A_RD1, 0, "post_clr_rd1"); chk(A_RD2, 0, "post_clr_rd2");
      if (i == 0) chk(Z_RD1, 0, "post_clr_noz0");
      step;
    end

    // reset at clr_idx == 10
    clr = 1'b1;
    step; clr = 1'b0;
    for (int k = 0; k < 10; k++) step;
    rst = 1'b1;
    step; rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk(A_BUSY, 1, "rrst_busy");
      chk(D_BUSY, (k < 24) ? 1 : 0, "rrst_busy_d24");
      step;
    end
    chk(A_BUSY, 0, "rrst_done"); chk(D_BUSY, 0, "rrst_done_d24");

    // out-of-range write on DEPTH=24
    we0 = 1'b1; wa0 = 5'd30; wd0 = 32'hCAFE; ra1 = 5'd30;
    chk(D_RD1, 0, "oor_no_bypass"); chk(A_RD1, 32'hCAFE, "inrange_bypass30");
    step; we0 = 1'b0;
    chk(D_RD1, 0, "oor_read30"); chk(A_RD1, 32'hCAFE, "inrange_read30");
    step;

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the core's 2R1W register file: configurable width and depth, two write ports with fixed priority, and write-to-read bypass. It adds a hardware clear sequencer, so every entry reads 0 after reset or after a runtime clear request. It sits in the decode/writeback stage of the RISC-V core. Port 1 carries the late writeback path (e.g. load return) and port 0 the ALU writeback.

Parameters:
DWIDTH, 32, data width of each entry
AWIDTH, 5, address width
DEPTH, 32, number of entries; DEPTH <= 2**AWIDTH
ZERO_REG, 1, 1 = entry 0 is hardwired to zero (RISC-V x0); 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
clr  in  1  runtime clear request, sampled only in READY
busy  out  1  high while the clear sequence runs
we0  in  1  write enable, port 0
wa0  in  AWIDTH  write address, port 0
wd0  in  DWIDTH  write data, port 0
we1  in  1  write enable, port 1 (wins over port 0)
wa1  in  AWIDTH  write address, port 1
wd1  in  DWIDTH  write data, port 1
ra1  in  AWIDTH  read address 1
ra2  in  AWIDTH  read address 2
rd1  out  DWIDTH  read data 1, combinational
rd2  out  DWIDTH  read data 2, combinational

Behaviour:
- FSM states: CLEAR, READY. A clear index clr_idx of AWIDTH bits drives the sequence.
- rst high at an edge: state <= CLEAR, clr_idx <= 0. Memory contents are not otherwise touched. busy = 1 while rst is held.
- CLEAR (rst low), each edge: mem[clr_idx] <= 0 and clr_idx <= clr_idx+1.
  - When clr_idx == DEPTH-1: state <= READY and clr_idx <= 0.
  - The clear therefore takes exactly DEPTH edges after rst deasserts.
- READY with clr = 1 at an edge: state <= CLEAR and clr_idx <= 0. User writes in that same cycle are still committed.
- busy = (state == CLEAR). It is a registered state decode with no combinational input path.
- User writes are committed only in READY and ignored entirely while busy.
- Write rules (READY):
  - weN and waN < DEPTH: mem[waN] <= wdN.
  - waN == 0 with ZERO_REG=1: write dropped.
  - waN >= DEPTH: write dropped.
  - we0 and we1 to the same address: port 1 data is stored.
  - Writes to different addresses: both are stored in the same cycle.
- Read rules (combinational, in priority order):
  1. busy → rd = 0.
  2. ra >= DEPTH → 0.
  3. ra == 0 with ZERO_REG=1 → 0.
  4. we1 and wa1 == ra → wd1 (bypass).
  5. we0 and wa0 == ra → wd0 (bypass).
  6. Otherwise mem[ra].
- Bypass applies only to writes that will actually commit, i.e. never to a dropped write.
- rd1 and rd2 are independent. The same address on both read ports returns the same value.
- Mid-operation events:
  - rst asserted during CLEAR restarts the sequence from index 0.
  - clr asserted during CLEAR is ignored; the sequence is not extended.
- Reset values: busy = 1, rd1 = rd2 = 0.
- Latency: write-to-read is 0 cycles via bypass. Committed data is visible from mem on the next cycle.

Test Plan:
- Reset/clear: hold rst 3 cycles, release; count edges with busy=1 → exactly 32 (DEPTH=32). Then ra1=5, ra2=31 → rd1=rd2=0. we0=1, wa0=7 during busy → mem[7] stays 0 after busy falls.
- Write/read and x0: write 0xDEADBEEF to 3 via port 0, then read ra1=3 → 0xDEADBEEF. Write 0x1234 to addr 0 → rd=0. With ZERO_REG=0, the same write → rd=0x1234.
- Dual write and priority: we0 wa0=4 wd0=0xAAAA and we1 wa1=4 wd1=0x5555 in the same cycle → next-cycle read of 4 = 0x5555. Ports to addrs 8/9 in the same cycle → both stored.
- Bypass: ra1=10, we0 wa0=10 wd0=0x77 in the same cycle → rd1=0x77 combinationally. Add we1 wa1=10 wd1=0x99 → rd1=0x99. ra2=0 with we0 wa0=0 → rd2=0.
- Runtime clear: fill regs 1..31 with their index, pulse clr for 1 cycle → busy high 32 edges, rd=0 throughout. Afterwards all entries read 0. A clr pulse during busy does not extend busy beyond 32 edges.
- Reset mid-clear and out-of-range: with DEPTH=24, assert rst at clr_idx=10 → busy lasts 24 edges after release. Write to addr 30 → ignored, and read of addr 30 returns 0.
